edram_refresh_sched: RTL

- Row-activation scheduler for the eDRAM array.
- Shares the single wordline/write-enable port between host read/write requests and periodic refresh activations, so every row is activated before cell charge leaks.
- A refresh is one activation with write_en low: the cell drives the bitline and recaptures its own value, which restores charge and clears the leak timer.
- Sits between the host request interface and the row decoder / bitline datapath.

---
 rtl/edram_refresh_sched.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/edram_refresh_sched.sv
`default_nettype none
// ============================================================================
// Module      : edram_refresh_sched
// Description : Row-activation scheduler sharing the eDRAM wordline port
//               between host reads/writes and periodic refresh activations.
//               Optional statistics counters enabled by EDRAM_REF_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module edram_refresh_sched #(
    parameter int ROWS        = 256,
    parameter int ROW_AW      = 8,
    parameter int REF_PERIOD  = 7,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ref_enable,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_we,
    input  logic [ROW_AW-1:0]                  req_addr,
    output logic [ROW_AW-1:0]                  row_addr,
    output logic                               wl_en,
    output logic                               write_en,
    output logic                               rd_valid,
    output logic                               round_done,
    output logic                               ref_overflow,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
    output logic [CNT_W-1:0]                   ref_count,
    output logic [CNT_W-1:0]                   urgent_count
);

    localparam int c_PEND_W  = $clog2(MAX_PENDING + 1);
    localparam int c_TIMER_W = $clog2(REF_PERIOD);

    localparam logic [c_TIMER_W-1:0] c_TIMER_RELOAD = c_TIMER_W'(REF_PERIOD - 1);
    localparam logic [c_PEND_W-1:0]  c_PEND_FULL    = c_PEND_W'(MAX_PENDING);
    localparam logic [ROW_AW-1:0]    c_LAST_ROW     = ROW_AW'(ROWS - 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACTIVE = 2'd1;
    localparam logic [1:0] c_S_PRE    = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic [c_PEND_W-1:0]  r_pending;
    logic                 r_overflow;
    logic [ROW_AW-1:0]    r_ptr;
    logic                 r_wl_en;
    logic                 r_write_en;
    logic                 r_rd_valid;
    logic                 r_round_done;
    logic [ROW_AW-1:0]    r_row_addr;

    logic w_tick;
    logic w_urgent;
    logic w_sel_ref;
    logic w_sel_host;

    assign w_tick   = ref_enable && (r_timer == '0);
    assign w_urgent = (r_pending == c_PEND_FULL);

    assign req_ready    = (r_state == c_S_IDLE) && !w_urgent;
    assign row_addr     = r_row_addr;
    assign wl_en        = r_wl_en;
    assign write_en     = r_write_en;
    assign rd_valid     = r_rd_valid;
    assign round_done   = r_round_done;
    assign ref_overflow = r_overflow;
    assign pending      = r_pending;

    always_comb begin
        w_next_state = r_state;
        w_sel_ref    = 1'b0;
        w_sel_host   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_urgent) begin
                    w_sel_ref    = 1'b1;
                    w_next_state = c_S_ACTIVE;
                end else if (req_valid) begin
                    w_sel_host   = 1'b1;
                    w_next_state = c_S_ACTIVE;
                end else if (r_pending != '0) begin
                    w_sel_ref    = 1'b1;
                    w_next_state = c_S_ACTIVE;
                end
            end
            c_S_ACTIVE: w_next_state = c_S_PRE;
            c_S_PRE:    w_next_state = c_S_IDLE;
            default:    w_next_state = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= c_TIMER_RELOAD;
        end else if (ref_enable) begin
            r_timer <= (r_timer == '0) ? c_TIMER_RELOAD : r_timer - c_TIMER_W'(1);
        end
    end

    // A tick and a refresh issue in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            case ({w_tick, w_sel_ref})
                2'b10: begin
                    if (w_urgent) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_pending <= r_pending + c_PEND_W'(1);
                    end
                end
                2'b01:   r_pending <= r_pending - c_PEND_W'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_sel_ref) begin
            r_ptr <= (r_ptr == c_LAST_ROW) ? '0 : r_ptr + ROW_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wl_en      <= 1'b0;
            r_write_en   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_round_done <= 1'b0;
            r_row_addr   <= '0;
        end else begin
            r_wl_en      <= w_sel_ref || w_sel_host;
            r_write_en   <= w_sel_host && req_we;
            r_rd_valid   <= w_sel_host && !req_we;
            r_round_done <= w_sel_ref && (r_ptr == c_LAST_ROW);
            if (w_sel_ref) begin
                r_row_addr <= r_ptr;
            end else if (w_sel_host) begin
                r_row_addr <= req_addr;
            end
        end
    end

`ifdef EDRAM_REF_STATS_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic             r_is_ref;
    logic [CNT_W-1:0] r_ref_count;
    logic [CNT_W-1:0] r_urgent_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_ref       <= 1'b0;
            r_ref_count    <= '0;
            r_urgent_count <= '0;
        end else begin
            r_is_ref <= w_sel_ref;
            if ((r_state == c_S_ACTIVE) && r_is_ref && (r_ref_count != c_CNT_MAX)) begin
                r_ref_count <= r_ref_count + CNT_W'(1);
            end
            if (w_sel_ref && w_urgent && (r_urgent_count != c_CNT_MAX)) begin
                r_urgent_count <= r_urgent_count + CNT_W'(1);
            end
        end
    end

    assign ref_count    = r_ref_count;
    assign urgent_count = r_urgent_count;
`else
    assign ref_count    = '0;
    assign urgent_count = '0;
`endif

endmodule
`default_nettype wire
